disp_scan_ctrl: RTL and testbench

//  Time-multiplexed scan controller for an N-digit common-anode 7-segment display.
//  - Shares a single disp_dec nibble-to-segment decoder across all digits.
//  - Steps one digit per slot, with a blanking guard at the start of each slot to prevent ghosting.
//  - Double-buffers digit values; a new value set is accepted only at frame boundaries.

---
 rtl/disp_scan_ctrl.sv | 134 +++++++++++++
 tb/tb_disp_scan_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/disp_scan_ctrl.sv
// Multiplexed N-digit 7-segment scan controller with blanking guard and frame-synchronous shadow update.
// Optional leading-zero suppression: define DISP_LEADING_ZERO_BLANK_EN.
module disp_scan_ctrl #(
    parameter int N_DIGITS  = 4,
    parameter int PRESCALE  = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [4*N_DIGITS-1:0] digits_i,
    input  logic                  upd_req,
    output logic                  upd_ack,
    output logic [3:0]            nib_o,
    output logic [N_DIGITS-1:0]   an_o,
    output logic                  frame_o
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IW = $clog2(N_DIGITS);
    localparam int SW = 4 * N_DIGITS;

    localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] BLK_LAST = CW'(BLANK_CYC - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        SHOW
    } state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [SW-1:0]       shadow_q, shadow_d;
    logic [N_DIGITS-1:0] an_q, an_d;
    logic [3:0]          nib_q, nib_d;
    logic                ack_q, ack_d;
    logic                frame_q, frame_d;
    logic                cap;

    function automatic logic lz_dark(input logic [IW-1:0] idx,
                                     input logic [SW-1:0] sh);
`ifdef DISP_LEADING_ZERO_BLANK_EN
        return (idx != '0) && ((sh >> {idx, 2'b00}) == '0);
`else
        return 1'b0 & (|idx) & (|sh);
`endif
    endfunction

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                idx_d = '0;
                cnt_d = '0;
                if (en) state_d = BLANK;
            end
            BLANK: begin
                if (!en) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == BLK_LAST) state_d = SHOW;
                end
            end
            SHOW: begin
                if (!en) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = BLANK;
                    cnt_d   = '0;
                    idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are registered from next-state, so they line up with the state they describe.
    // Shadow loads as the frame-end cycle begins; nib/an for that cycle still use the old frame.
    always_comb begin
        frame_d  = (state_d == SHOW) && (idx_d == IDX_LAST) &&
                   (cnt_d == CNT_LAST);
        cap      = upd_req && ((state_q == IDLE) || frame_d);
        ack_d    = cap;
        shadow_d = cap ? digits_i : shadow_q;
        nib_d    = '0;
        an_d     = '1;
        if (state_d != IDLE) nib_d = shadow_q[{idx_d, 2'b00} +: 4];
        if (state_d == SHOW && !lz_dark(idx_d, shadow_q)) an_d[idx_d] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            shadow_q <= '0;
            an_q     <= '1;
            nib_q    <= '0;
            ack_q    <= 1'b0;
            frame_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            an_q     <= an_d;
            nib_q    <= nib_d;
            ack_q    <= ack_d;
            frame_q  <= frame_d;
        end
    end

    assign an_o    = an_q;
    assign nib_o   = nib_q;
    assign upd_ack = ack_q;
    assign frame_o = frame_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Self-checking bench for disp_scan_ctrl: time-indexed reference model,
// directed vector tables and random stimulus.
module tb_disp_scan_ctrl;

    localparam int N  = 4;
    localparam int P  = 8;
    localparam int B  = 2;
    localparam int NP = N * P;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        upd_req = 1'b0;
    logic [15:0] digits = '0;
    logic        upd_ack;
    logic        frame_o;
    logic [3:0]  nib_o;
    logic [3:0]  an_o;

    always #5 clk = ~clk;

    disp_scan_ctrl #(
        .N_DIGITS (N),
        .PRESCALE (P),
        .BLANK_CYC(B)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .digits_i(digits),
        .upd_req (upd_req),
        .upd_ack (upd_ack),
        .nib_o   (nib_o),
        .an_o    (an_o),
        .frame_o (frame_o)
    );

    int total = 0;
    int bad = 0;

    bit          m_run;
    int          m_t;
    logic [15:0] m_sh;
    logic [3:0]  e_an;
    logic [3:0]  e_nib;
    logic        e_fr;
    logic        e_ack;

    typedef struct {
        int         t;
        logic [3:0] an;
        logic [3:0] nib;
        logic       fr;
    } vec_t;

    typedef struct {
        logic [15:0]      val;
        logic [3:0][3:0]  an;
    } lz_vec_t;

    vec_t    tbl[11];
    lz_vec_t lzt[2];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic lz(input int idx, input logic [15:0] sh);
`ifdef DISP_LEADING_ZERO_BLANK_EN
        return (idx > 0) && ((sh >> (4 * idx)) == 16'h0);
`else
        return (idx < 0) && (sh == 16'h1);
`endif
    endfunction

    task automatic model_reset();
        m_run = 1'b0;
        m_t   = 0;
        m_sh  = '0;
        e_an  = 4'hF;
        e_nib = '0;
        e_fr  = 1'b0;
        e_ack = 1'b0;
    endtask

    // One clock: advance the scan-time model on the edge, compare on the falling edge.
    task automatic tick();
        bit          prev;
        int          idx;
        int          pos;
        logic [15:0] old;
        @(posedge clk);
        prev = m_run;
        old  = m_sh;
        if (!m_run) begin
            if (en) begin
                m_run = 1'b1;
                m_t   = 0;
            end
        end else if (!en) begin
            m_run = 1'b0;
            m_t   = 0;
        end else begin
            m_t++;
        end
        idx   = (m_t / P) % N;
        pos   = m_t % P;
        e_fr  = m_run && ((m_t % NP) == NP - 1);
        e_ack = upd_req && (!prev || e_fr);
        e_nib = m_run ? 4'((old >> (4 * idx)) & 16'hF) : 4'h0;
        e_an  = 4'hF;
        if (m_run && pos >= B && !lz(idx, old)) e_an[idx] = 1'b0;
        if (e_ack) m_sh = digits;
        @(negedge clk);
        chk("an_o", an_o, e_an);
        chk("nib_o", nib_o, e_nib);
        chk("frame_o", frame_o, e_fr);
        chk("upd_ack", upd_ack, e_ack);
    endtask

    initial begin
        int n;
        tbl[0]  = '{0,  4'hF, 4'h1, 1'b0};
        tbl[1]  = '{1,  4'hF, 4'h1, 1'b0};
        tbl[2]  = '{2,  4'hE, 4'h1, 1'b0};
        tbl[3]  = '{7,  4'hE, 4'h1, 1'b0};
        tbl[4]  = '{8,  4'hF, 4'h2, 1'b0};
        tbl[5]  = '{10, 4'hD, 4'h2, 1'b0};
        tbl[6]  = '{18, 4'hB, 4'h3, 1'b0};
        tbl[7]  = '{26, 4'h7, 4'h4, 1'b0};
        tbl[8]  = '{31, 4'h7, 4'h4, 1'b1};
        tbl[9]  = '{32, 4'hF, 4'h1, 1'b0};
        tbl[10] = '{63, 4'h7, 4'h4, 1'b1};
`ifdef DISP_LEADING_ZERO_BLANK_EN
        lzt[0] = '{16'h0050, {4'hF, 4'hF, 4'hD, 4'hE}};
        lzt[1] = '{16'h0000, {4'hF, 4'hF, 4'hF, 4'hE}};
`else
        lzt[0] = '{16'h0050, {4'h7, 4'hB, 4'hD, 4'hE}};
        lzt[1] = '{16'h0000, {4'h7, 4'hB, 4'hD, 4'hE}};
`endif

        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_an", an_o, 4'hF);
        chk("rst_nib", nib_o, 4'h0);
        chk("rst_ack", upd_ack, 1'b0);
        chk("rst_frame", frame_o, 1'b0);

        digits  = 16'h4321;
        upd_req = 1'b1;
        tick();
        chk("idle_load_ack", upd_ack, 1'b1);
        upd_req = 1'b0;

        en = 1'b1;
        for (int t = 0; t < 64; t++) begin
            tick();
            foreach (tbl[i]) begin
                if (tbl[i].t == t) begin
                    chk("scan_an", an_o, tbl[i].an);
                    chk("scan_nib", nib_o, tbl[i].nib);
                    chk("scan_frame", frame_o, tbl[i].fr);
                end
            end
        end

        repeat (9) tick();
        digits  = 16'h9876;
        upd_req = 1'b1;
        n = 0;
        while (!upd_ack && n < NP + 8) begin
            tick();
            n++;
        end
        chk("upd_ack_seen", upd_ack, 1'b1);
        chk("upd_ack_at_frame", frame_o, 1'b1);
        chk("upd_ack_latency", n, 23);
        upd_req = 1'b0;
        repeat (3) tick();
        chk("new_digit0_nib", nib_o, 4'h6);
        chk("new_digit0_an", an_o, 4'hE);

        repeat (18) tick();
        chk("dig2_show_an", an_o, 4'hB);
        en = 1'b0;
        tick();
        chk("disable_an", an_o, 4'hF);
        tick();
        en = 1'b1;
        repeat (3) tick();
        chk("restart_an", an_o, 4'hE);
        chk("restart_nib", nib_o, 4'h6);

        repeat (28) tick();
        digits  = 16'h0050;
        upd_req = 1'b1;
        tick();
        chk("edge_frame", frame_o, 1'b1);
        chk("edge_ack", upd_ack, 1'b1);
        en = 1'b0;
        tick();
        chk("edge_idle_an", an_o, 4'hF);
        chk("edge_idle_frame", frame_o, 1'b0);
        upd_req = 1'b0;

        en = 1'b1;
        repeat (11) tick();
        chk("pre_rst_nib", nib_o, 4'h5);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_an", an_o, 4'hF);
        chk("async_rst_nib", nib_o, 4'h0);
        chk("async_rst_ack", upd_ack, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b0;
        tick();

        foreach (lzt[v]) begin
            digits  = lzt[v].val;
            upd_req = 1'b1;
            tick();
            upd_req = 1'b0;
            en = 1'b1;
            for (int t = 0; t < NP; t++) begin
                tick();
                if (t % P == 4) begin
                    chk("lz_an", an_o, lzt[v].an[t / P]);
                    chk("lz_nib", nib_o,
                        4'((lzt[v].val >> (4 * (t / P))) & 16'hF));
                end
            end
            en = 1'b0;
            tick();
        end

        for (int c = 0; c < 3000; c++) begin
            if (upd_req && upd_ack) begin
                upd_req = 1'b0;
            end else if (!upd_req && $urandom_range(0, 19) == 0) begin
                upd_req = 1'b1;
                if ($urandom_range(0, 2) == 0)
                    digits = 16'($urandom_range(0, 255));
                else
                    digits = 16'($urandom);
            end
            en = ($urandom_range(0, 199) != 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
